// File: rtl/simon_key_sequencer.sv
// SIMON32/64 sequential key expander: loads a 64-bit master key and streams
// round keys k0..k(NUM_ROUNDS-1) from a 4-word sliding window over valid/ready.
module simon_key_sequencer #(
  parameter int unsigned NUM_ROUNDS = 32,
  parameter logic [61:0] Z_SEQ      = 62'b01100111000011010100100010111110110011100001101010010001011111,
  parameter logic [15:0] C_CONST    = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic        abort,
  output logic [15:0] rk_data,
  output logic [4:0]  rk_index,
  output logic        rk_last,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic        busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS - 1);

  state_t      state, state_nxt;
  logic [15:0] w0, w1, w2, w3;
  logic [4:0]  idx;
  logic [15:0] t, u, nxt;
  logic        accept_key, beat, is_last;

  assign is_last    = (idx == LAST_IDX);
  assign accept_key = (state == IDLE) && key_valid && !abort;
  assign beat       = (state == EMIT) && rk_ready && !abort;

  // Window holds k(idx)..k(idx+3); nxt is k(idx+4).
  always_comb begin
    t   = {w3[2:0], w3[15:3]} ^ w1;
    u   = t ^ {t[0], t[15:1]};
    nxt = u ^ w0 ^ {15'b0, Z_SEQ[idx]} ^ C_CONST;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept_key) state_nxt = EMIT;
      EMIT: if (abort || (beat && is_last)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    key_ready = (state == IDLE);
    rk_valid  = (state == EMIT);
    busy      = (state == EMIT);
    rk_data   = (state == EMIT) ? w0  : '0;
    rk_index  = (state == EMIT) ? idx : '0;
    rk_last   = (state == EMIT) && is_last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w0  <= '0;
      w1  <= '0;
      w2  <= '0;
      w3  <= '0;
      idx <= '0;
    end else if (accept_key) begin
      w0  <= key_in[15:0];
      w1  <= key_in[31:16];
      w2  <= key_in[47:32];
      w3  <= key_in[63:48];
      idx <= '0;
    end else if ((state == EMIT) && abort) begin
      idx <= '0;
    end else if (beat) begin
      if (is_last) begin
        idx <= '0;
      end else begin
        w0  <= w1;
        w1  <= w2;
        w2  <= w3;
        w3  <= nxt;
        idx <= idx + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_simon_key_sequencer.sv
// Directed bench for simon_key_sequencer: standard vector, backpressure,
// abort, async reset, back-to-back keys and a 5-round instance.
module tb_simon_key_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        key_valid, key_ready, abort;
  logic [15:0] rk_data;
  logic [4:0]  rk_index;
  logic        rk_last, rk_valid, rk_ready, busy;

  logic [63:0] key_in5;
  logic        key_valid5, key_ready5, abort5;
  logic [15:0] rk_data5;
  logic [4:0]  rk_index5;
  logic        rk_last5, rk_valid5, rk_ready5, busy5;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] STD_KEY = 64'h1918_1110_0908_0100;
  localparam logic [63:0] KEY_B   = 64'h0123_4567_89AB_CDEF;

  logic [15:0] ks [0:31];
  logic [15:0] std_head [0:4];
  logic [61:0] zseq;

  always #5 clk = ~clk;

  simon_key_sequencer dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .abort(abort), .rk_data(rk_data),
    .rk_index(rk_index), .rk_last(rk_last), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .busy(busy)
  );

  simon_key_sequencer #(.NUM_ROUNDS(5)) dut5 (
    .clk(clk), .rst(rst), .key_in(key_in5), .key_valid(key_valid5),
    .key_ready(key_ready5), .abort(abort5), .rk_data(rk_data5),
    .rk_index(rk_index5), .rk_last(rk_last5), .rk_valid(rk_valid5),
    .rk_ready(rk_ready5), .busy(busy5)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference key schedule from the SIMON32/64 recurrence.
  task automatic build_ks(input logic [63:0] key);
    logic [15:0] r3, t, u;
    ks[0] = key[15:0];
    ks[1] = key[31:16];
    ks[2] = key[47:32];
    ks[3] = key[63:48];
    for (int i = 0; i < 28; i++) begin
      r3 = (ks[i+3] >> 3) | (ks[i+3] << 13);
      t  = r3 ^ ks[i+1];
      u  = t ^ ((t >> 1) | (t << 15));
      ks[i+4] = u ^ ks[i] ^ {15'b0, zseq[i]} ^ 16'hFFFC;
    end
  endtask

  // Offer a key and wait (bounded) until it is accepted; leaves key_valid low.
  task automatic send_key(input logic [63:0] key);
    int n;
    key_in    = key;
    key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("send_key_timeout", 64'(n), 64'd0);
    tick();
    key_valid = 1'b0;
  endtask

  // Full-rate stream of 32 beats starting from the k0 sample point.
  task automatic run_stream();
    rk_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("strm_valid", 64'(rk_valid), 64'd1);
      check("strm_data",  64'(rk_data),  64'(ks[i]));
      check("strm_index", 64'(rk_index), 64'(i));
      check("strm_last",  64'(rk_last),  64'(i == 31));
      check("strm_kready", 64'(key_ready), 64'd0);
      tick();
    end
  endtask

  initial begin
    int e, stall, cyc, beats;
    logic rdy;

    zseq = 62'b01100111000011010100100010111110110011100001101010010001011111;
    std_head[0] = 16'h0100; std_head[1] = 16'h0908; std_head[2] = 16'h1110;
    std_head[3] = 16'h1918; std_head[4] = 16'h71C3;

    rst = 1'b1; key_in = '0; key_valid = 1'b0; abort = 1'b0; rk_ready = 1'b0;
    key_in5 = '0; key_valid5 = 1'b0; abort5 = 1'b0; rk_ready5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_kready", 64'(key_ready), 64'd1);
    check("rst_valid",  64'(rk_valid),  64'd0);
    check("rst_busy",   64'(busy),      64'd0);
    check("rst_data",   64'(rk_data),   64'd0);
    check("rst_index",  64'(rk_index),  64'd0);
    check("rst_last",   64'(rk_last),   64'd0);
    rst = 1'b0;
    tick();

    // NUM_ROUNDS = 5 instance
    key_in5 = STD_KEY; key_valid5 = 1'b1; rk_ready5 = 1'b1;
    tick();
    key_valid5 = 1'b0;
    beats = 0;
    for (int c = 0; c < 12; c++) begin
      if (rk_valid5) begin
        check("r5_index", 64'(rk_index5), 64'(beats));
        check("r5_data",  64'(rk_data5),  64'(std_head[beats % 5]));
        check("r5_last",  64'(rk_last5),  64'(beats == 4));
        beats++;
      end
      tick();
    end
    check("r5_beats", 64'(beats), 64'd5);

    // Standard vector at full rate
    build_ks(STD_KEY);
    for (int i = 0; i < 5; i++) check("ks_model", 64'(ks[i]), 64'(std_head[i]));
    send_key(STD_KEY);
    check("std_k0_latency", 64'(rk_data), 64'h0100);
    run_stream();
    check("std_end_valid",  64'(rk_valid),  64'd0);
    check("std_end_kready", 64'(key_ready), 64'd1);

    // Backpressure with a 5-cycle stall at index 4
    send_key(STD_KEY);
    e = 0; stall = 0; cyc = 0;
    while (e < 32 && cyc < 400) begin
      check("bp_valid", 64'(rk_valid), 64'd1);
      check("bp_index", 64'(rk_index), 64'(e));
      check("bp_data",  64'(rk_data),  64'(ks[e]));
      if (e == 4 && stall < 5) begin
        rdy = 1'b0;
        stall++;
        check("bp_stall_data", 64'(rk_data), 64'h71C3);
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      rk_ready = rdy;
      tick();
      if (rdy) e++;
      cyc++;
    end
    check("bp_done", 64'(e), 64'd32);
    check("bp_end_valid", 64'(rk_valid), 64'd0);

    // Abort at index 10
    send_key(STD_KEY);
    rk_ready = 1'b1;
    cyc = 0;
    while (rk_index != 5'd10 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("ab_reach10", 64'(rk_index), 64'd10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_valid",  64'(rk_valid),  64'd0);
    check("ab_kready", 64'(key_ready), 64'd1);
    check("ab_busy",   64'(busy),      64'd0);

    // Abort in IDLE blocks acceptance
    key_in = KEY_B; key_valid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; key_valid = 1'b0;
    check("ab_idle_busy",  64'(busy),      64'd0);
    check("ab_idle_valid", 64'(rk_valid),  64'd0);

    // Restart with a new key after abort, then async reset at index 17
    build_ks(KEY_B);
    send_key(KEY_B);
    check("re_k0",    64'(rk_data),  64'hCDEF);
    check("re_index", 64'(rk_index), 64'd0);
    rk_ready = 1'b1;
    cyc = 0;
    while (rk_index != 5'd17 && cyc < 50) begin
      check("re_data", 64'(rk_data), 64'(ks[rk_index]));
      tick();
      cyc++;
    end
    check("rr_reach17", 64'(rk_index), 64'd17);
    #2 rst = 1'b1;
    #1;
    check("rr_valid",  64'(rk_valid),  64'd0);
    check("rr_busy",   64'(busy),      64'd0);
    check("rr_kready", 64'(key_ready), 64'd1);
    check("rr_data",   64'(rk_data),   64'd0);
    check("rr_index",  64'(rk_index),  64'd0);
    check("rr_last",   64'(rk_last),   64'd0);
    #1 rst = 1'b0;
    tick();
    check("rr_stay_idle", 64'(rk_valid), 64'd0);

    // Back-to-back: second key held valid throughout the first stream
    build_ks(STD_KEY);
    key_in = STD_KEY; key_valid = 1'b1;
    tick();
    key_in = KEY_B;
    run_stream();
    check("b2b_gap_valid",  64'(rk_valid),  64'd0);
    check("b2b_gap_kready", 64'(key_ready), 64'd1);
    tick();
    key_valid = 1'b0;
    check("b2b_k0_valid", 64'(rk_valid), 64'd1);
    check("b2b_k0_data",  64'(rk_data),  64'hCDEF);
    check("b2b_k0_index", 64'(rk_index), 64'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("b2b_abort_idle", 64'(rk_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_key_sequencer.md
Name: simon_key_sequencer

Overview:
- Sequential round-key generator and controller for the SIMON32/64 pipelined model.
- Accepts a 64-bit master key over a valid/ready handshake.
- Runs the key-expansion recurrence one word at a time in a 4-word sliding window, then streams round keys k0..k(NUM_ROUNDS-1) in order to the round pipeline over a second valid/ready handshake with backpressure.
- Replaces a fully unrolled key-expansion chain, so key expansion costs one datapath instead of 28.

Parameters:
- NUM_ROUNDS, 32, number of round keys emitted per master key. Legal range 5..32.
- Z_SEQ, 62'b01100111000011010100100010111110110011100001101010010001011111, constant sequence z0. Bit j (LSB = bit 0) is used when generating word k(j+4).
- C_CONST, 16'hFFFC, round constant c, truncated to 16 bits.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  64  master key {k3,k2,k1,k0}, with k0 = key_in[15:0].
- key_valid  input  1  master key offered.
- key_ready  output  1  sequencer can accept a key; high only in IDLE.
- abort  input  1  synchronous cancel of the current key stream.
- rk_data  output  16  current round key.
- rk_index  output  5  index i of rk_data (0..NUM_ROUNDS-1).
- rk_last  output  1  high when rk_index == NUM_ROUNDS-1.
- rk_valid  output  1  rk_data/rk_index/rk_last valid.
- rk_ready  input  1  consumer accepts the current round key.
- busy  output  1  high in EMIT state.

Behaviour:
- States: IDLE, EMIT.
- Reset (asynchronous, any state):
  - state = IDLE; window w0..w3 = 0; idx = 0.
  - Outputs: key_ready = 1, rk_valid = 0, busy = 0, rk_data = 0, rk_index = 0, rk_last = 0.
- IDLE:
  - key_ready = 1; rk_valid = 0.
  - On key_valid & key_ready & !abort: w0..w3 <= k0..k3, idx <= 0, state <= EMIT.
  - Latency: key accepted on edge N; rk_valid = 1 with k0 in the cycle after edge N.
- EMIT:
  - rk_valid = 1, rk_data = w0, rk_index = idx, key_ready = 0.
  - All outputs hold stable while rk_valid & !rk_ready.
- Beat accepted (rk_valid & rk_ready):
  - Shift: w0 <= w1, w1 <= w2, w2 <= w3, w3 <= nxt; idx <= idx + 1.
  - If rk_last: state <= IDLE, window unchanged, idx <= 0.
- Next-word recurrence, with ROR = 16-bit rotate right and all arithmetic as 16-bit XOR:
  - t = ROR3(w3) ^ w1
  - u = t ^ ROR1(t)
  - nxt = u ^ w0 ^ {15'b0, Z_SEQ[idx]} ^ C_CONST
  - nxt is generated when the window holds k(idx)..k(idx+3), so it produces k(idx+4).
  - nxt is needed only while idx+4 <= NUM_ROUNDS-1. Its value at higher idx is don't-care; the Z_SEQ index never exceeds 27 in that case.
- Throughput: one round key per clock while rk_ready is held high.
- Turnaround: one dead cycle (IDLE) between the last key of one stream and k0 of the next. key_ready is never high in the same cycle as rk_valid.
- abort:
  - Checked in any state, with priority over both handshakes.
  - In EMIT: state <= IDLE, idx <= 0, rk_valid low next cycle. A beat presented in the abort cycle counts as not consumed.
  - In IDLE: blocks key acceptance that cycle; otherwise no effect.
- key_valid while busy: ignored (key_ready = 0). The upstream holds the key.
- rk_ready while IDLE: ignored.
- Async rst asserted mid-stream: immediate return to the reset values. The stream restarts only after a new key handshake.
- No combinational path from key_valid to key_ready, or from rk_ready to rk_valid.

Test Plan:
- Standard vector:
  - Stimulus: key_in = 64'h1918_1110_0908_0100, rk_ready held 1.
  - Required: rk_data = 0100, 0908, 1110, 1918, 71C3 on consecutive cycles with rk_index 0..4.
  - Required: 32 beats total, rk_last only on index 31, then key_ready = 1 one cycle after the last beat.
- Backpressure:
  - Stimulus: same key; toggle rk_ready randomly; stall 5 cycles at index 4.
  - Required: rk_data holds 71C3 and rk_index holds 4 for the whole stall; the sequence is identical to the unstalled run, with no skipped or duplicated index.
- Abort:
  - Stimulus: assert abort in the cycle rk_index = 10 with rk_ready = 1.
  - Required: rk_valid = 0 next cycle, key_ready = 1. A new key then restarts at index 0 with the correct k0.
- Reset mid-stream:
  - Stimulus: assert rst asynchronously (between edges) at index 17.
  - Required: rk_valid and busy drop without waiting for a clock edge; all outputs at their reset values.
- Back-to-back keys:
  - Stimulus: second key_valid held high throughout the first stream.
  - Required: the second key is accepted only in IDLE after index 31; k0 of the second key appears exactly 2 cycles after the last beat of the first stream.
- NUM_ROUNDS = 5:
  - Stimulus: standard key.
  - Required: exactly 5 beats, rk_last on index 4 with rk_data = 71C3.
